// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: command-driven sequencer that owns a WIDTH-bit Gray counter.
// LOAD sets the binary start value; RUN steps the counter N times up or down,
// then pulses done for one cycle. abort ends a RUN early.
// Optional build macro: GRAY_SEQ_STEP_CHK_EN adds a sticky single-bit-change
// checker on every RUN step (err). Without it err is tied low.
module gray_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic [WIDTH-1:0] gray_out,
  output logic [CNT_W-1:0] steps_left,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             accept_s;
  logic             step_s;

  // Commands are only taken in IDLE, and an asserted abort also holds them off.
  assign cmd_ready = (state_q == ST_IDLE) && !abort;
  assign accept_s  = cmd_valid && cmd_ready;
  // A RUN step happens on every RUN edge unless abort wins that edge.
  assign step_s    = (state_q == ST_RUN) && !abort;

  // Next-state, counter and status logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    steps_d   = steps_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          aborted_d = 1'b0;
          if (!cmd_op) begin
            b_d = cmd_arg[WIDTH-1:0];
          end else begin
            dir_d   = cmd_dir;
            steps_d = cmd_arg;
            state_d = (cmd_arg == ZERO_C) ? ST_DONE : ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          b_d     = dir_q ? (b_q + ONE_W) : (b_q - ONE_W);
          steps_d = steps_q - ONE_C;
          if (steps_q <= ONE_C) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Gray code is registered alongside b so it never glitches.
    gray_d = b_d ^ (b_d >> 1);
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      b_q       <= ZERO_W;
      gray_q    <= ZERO_W;
      steps_q   <= ZERO_C;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      gray_q    <= gray_d;
      steps_q   <= steps_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign gray_out   = gray_q;
  assign steps_left = steps_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

`ifdef GRAY_SEQ_STEP_CHK_EN
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             chk_pend_q, chk_pend_d;
  logic             err_q, err_d;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != ZERO_W) && ((v & (v - ONE_W)) == ZERO_W);
  endfunction

  // Remember the code before each step and compare once the new code lands.
  always_comb begin
    prev_gray_d = prev_gray_q;
    chk_pend_d  = 1'b0;
    err_d       = err_q;
    if (step_s) begin
      prev_gray_d = gray_q;
      chk_pend_d  = 1'b1;
    end else begin
      chk_pend_d  = 1'b0;
    end
    if (chk_pend_q && !is_onehot(prev_gray_q ^ gray_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Step-checker state; err is sticky until reset.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= ZERO_W;
      chk_pend_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      chk_pend_q  <= chk_pend_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: the driver computes expected Gray codes
// and run outcomes from a plain integer model and queues them; a monitor pops
// and compares whenever gray_out changes or done pulses.
module tb_gray_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             i_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_op = 1'b0;
  logic [CNT_W-1:0] cmd_arg = '0;
  logic             cmd_dir = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] gray_out;
  logic [CNT_W-1:0] steps_left;
  logic             busy, done, aborted, err;

  gray_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_dir(cmd_dir), .abort(abort),
    .gray_out(gray_out), .steps_left(steps_left), .busy(busy), .done(done),
    .aborted(aborted), .err(err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int gray;
    int steps;
    int ab;
    int busy_cycles;
  } done_t;

  done_t dq[$];
  int    gq[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    m_b = 0;
  int    last_gray = 0;
  bit    mon_en = 1'b0;
  int    prev_gray = 0;
  int    busy_cnt = 0;
  int    neg_cnt = 0;
  int    prev_acc = 0;
  int    exp_gap = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic push_gray(input int v);
    if (v != last_gray) begin
      gq.push_back(v);
      last_gray = v;
    end
  endtask

  always @(negedge i_clk) neg_cnt++;

  // Monitor: compare on every Gray change and every done pulse.
  always @(negedge i_clk) begin
    if (mon_en && rst_n) begin
      if (int'(gray_out) != prev_gray) begin
        if (gq.size() == 0) chk("unexpected_gray_change", int'(gray_out), prev_gray);
        else chk("gray_step", int'(gray_out), gq.pop_front());
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          done_t r;
          r = dq.pop_front();
          chk("done_gray", int'(gray_out), r.gray);
          chk("done_steps_left", int'(steps_left), r.steps);
          chk("done_aborted", int'(aborted), r.ab);
          chk("busy_cycles", busy_cnt, r.busy_cycles);
          chk("err_low", int'(err), 0);
        end
        busy_cnt = 0;
      end
    end else begin
      busy_cnt = 0;
    end
    prev_gray = int'(gray_out);
  end

  // Present a command and hold it until accepted; returns at the next negedge.
  task automatic send(input bit op, input int arg, input bit dir);
    bit rdy;
    bit got;
    int acc;
    got = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg[CNT_W-1:0];
    cmd_dir = dir;
    for (int w = 0; w < 100; w++) begin
      #1;
      rdy = cmd_ready;
      @(posedge i_clk);
      if (rdy) begin
        got = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    acc = neg_cnt;
    if (!got) chk("accept_timeout", 0, 1);
    else if (exp_gap >= 0) chk("accept_gap", acc - prev_acc, exp_gap);
    prev_acc = acc;
    @(negedge i_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic load_cmd(input int arg);
    m_b = arg & MASK;
    push_gray(to_gray(m_b));
    send(1'b0, arg, 1'($urandom % 2));
    exp_gap = 1;
  endtask

  // RUN n steps; with do_ab, abort is sampled on the edge after k steps (k < n).
  task automatic run_cmd(input int n, input bit up, input bit do_ab, input int k);
    int steps;
    done_t r;
    steps = do_ab ? k : n;
    for (int i = 0; i < steps; i++) begin
      m_b = up ? ((m_b + 1) & MASK) : ((m_b - 1) & MASK);
      push_gray(to_gray(m_b));
    end
    r.gray = to_gray(m_b);
    r.steps = do_ab ? (n - k) : 0;
    r.ab = do_ab ? 1 : 0;
    r.busy_cycles = do_ab ? (k + 1) : n;
    dq.push_back(r);
    send(1'b1, n, up);
    if (do_ab) begin
      repeat (k) @(negedge i_clk);
      abort = 1'b1;
      @(negedge i_clk);
      abort = 1'b0;
      exp_gap = k + 3;
    end else begin
      exp_gap = n + 2;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    bit up, ab;
    // Reset for three cycles.
    rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    rst_n = 1'b1;
    #1;
    chk("rst_gray", int'(gray_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_steps_left", int'(steps_left), 0);
    chk("rst_err", int'(err), 0);
    m_b = 0;
    last_gray = 0;
    mon_en = 1'b1;
    exp_gap = -1;

    run_cmd(5, 1'b1, 1'b0, 0);
    load_cmd(15);
    run_cmd(2, 1'b1, 1'b0, 0);
    load_cmd(0);
    run_cmd(3, 1'b0, 1'b0, 0);
    load_cmd(0);
    run_cmd(10, 1'b1, 1'b1, 3);
    load_cmd(5);
    chk("aborted_cleared", int'(aborted), 0);
    run_cmd(0, 1'b1, 1'b0, 0);
    run_cmd(4, 1'b0, 1'b1, 3);
    load_cmd(2);

    // abort held in IDLE blocks acceptance of a valid LOAD.
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_arg = 8'd9;
    #1;
    chk("ready_low_abort_idle", int'(cmd_ready), 0);
    repeat (2) @(negedge i_clk);
    cmd_valid = 1'b0;
    abort = 1'b0;
    #1;
    chk("no_load_under_abort", int'(gray_out), to_gray(m_b));
    exp_gap = -1;

    // Reset in the middle of a RUN: everything clears, no done follows.
    @(negedge i_clk);
    mon_en = 1'b0;
    send(1'b1, 8, 1'b1);
    repeat (2) @(negedge i_clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_gray", int'(gray_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_steps_left", int'(steps_left), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    repeat (3) @(negedge i_clk);
    rst_n = 1'b1;
    gq.delete();
    dq.delete();
    m_b = 0;
    last_gray = 0;
    mon_en = 1'b1;
    exp_gap = -1;
    repeat (12) @(negedge i_clk);
    chk("midrst_no_done", int'(done), 0);

    // Random LOAD/RUN mix with occasional aborts.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_cmd(int'($urandom_range(0, 255)));
      end else begin
        n = int'($urandom_range(0, 20));
        up = 1'($urandom % 2);
        ab = (n > 0) && ($urandom_range(0, 3) == 0);
        k = ab ? int'($urandom_range(0, n - 1)) : 0;
        run_cmd(n, up, ab, k);
      end
    end

    repeat (30) @(negedge i_clk);
    chk("gray_queue_drained", gq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
